// File: rtl/oam_dma.sv
// Sprite (OAM) DMA controller and CPU/DMA bus arbiter for the k6502 bus.
// Optional feature macro OAM_DMA_ALIGN_EN: the first READ lands on an even (parity==0) cycle.
module oam_dma #(
   parameter logic [15:0] REG_ADDR  = 16'h4014,
   parameter logic [15:0] DEST_ADDR = 16'h2004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_d,
   input  logic        cpu_rw,
   input  logic [7:0]  bus_d,
   output logic        cpu_rdy,
   output logic        dma_busy,
   output logic [15:0] dma_a,
   output logic [7:0]  dma_d,
   output logic        dma_rw
);

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

   state_t      state;
   logic [7:0]  page;
   logic [7:0]  idx;
   logic [7:0]  data_buf;
   logic        parity;
   logic        align_done;

`ifdef OAM_DMA_ALIGN_EN
   // Leaving ALIGN on an odd edge puts the first READ on an even cycle.
   assign align_done = parity;
`else
   assign align_done = 1'b1;
`endif

   assign dma_d = data_buf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         page     <= 8'h00;
         idx      <= 8'h00;
         data_buf <= 8'h00;
         parity   <= 1'b0;
         cpu_rdy  <= 1'b1;
         dma_busy <= 1'b0;
         dma_rw   <= 1'b1;
         dma_a    <= 16'h0000;
      end else begin
         parity <= ~parity;
         case (state)
            IDLE: begin
               if (!cpu_rw && (cpu_a == REG_ADDR)) begin
                  page    <= cpu_d;
                  idx     <= 8'h00;
                  cpu_rdy <= 1'b0;
                  state   <= HALT;
               end
            end
            HALT: begin
               // The 6502 ignores RDY during write cycles, so wait for a read.
               if (cpu_rw)
                  state <= ALIGN;
            end
            ALIGN: begin
               if (align_done) begin
                  state    <= READ;
                  dma_busy <= 1'b1;
                  dma_rw   <= 1'b1;
                  dma_a    <= {page, idx};
               end
            end
            READ: begin
               data_buf <= bus_d;
               dma_rw   <= 1'b0;
               dma_a    <= DEST_ADDR;
               state    <= WRITE;
            end
            WRITE: begin
               idx <= idx + 8'd1;
               if (idx == 8'hFF) begin
                  state    <= IDLE;
                  cpu_rdy  <= 1'b1;
                  dma_busy <= 1'b0;
                  dma_rw   <= 1'b1;
               end else begin
                  state  <= READ;
                  dma_rw <= 1'b1;
                  dma_a  <= {page, idx + 8'd1};
               end
            end
            default: begin
               state    <= IDLE;
               cpu_rdy  <= 1'b1;
               dma_busy <= 1'b0;
               dma_rw   <= 1'b1;
            end
         endcase
      end
   end

endmodule
